icb_slave_sram: RTL and testbench

ICB responder (slave) terminating the accelerator's ICB master port on a single-port synchronous on-chip SRAM (weight/imap/omap scratch).
- Accepts read/write commands, performs byte-masked writes and reads, and returns in-order responses through a credit-controlled response FIFO.
- Flags address errors on the response channel.
- Used as the memory-side model in subsystem sim and as the real scratch-buffer front end.

---
 rtl/icb_pkg.sv | 26 ++
 rtl/icb_rsp_fifo.sv | 55 +++++
 rtl/icb_slave_sram.sv | 115 +++++++++++
 tb/tb_icb_slave_sram.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/icb_pkg.sv
// Shared ICB bus constants and the response-entry layout
// used by the SRAM responder and its response FIFO.
package icb_pkg;

  localparam int ICB_AW = 32;
  localparam int ICB_DW = 32;
  localparam int ICB_MW = 4;

  typedef struct packed {
    logic              err;
    logic [ICB_DW-1:0] rdata;
  } icb_rsp_t;

  localparam int RSP_W = $bits(icb_rsp_t);

  function automatic icb_rsp_t rsp_pack(
    input logic              err,
    input logic [ICB_DW-1:0] rdata
  );
    icb_rsp_t r;
    r.err   = err;
    r.rdata = rdata;
    return r;
  endfunction

endpackage

// File: rtl/icb_rsp_fifo.sv
// Synchronous response FIFO with wrap-bit pointers;
// full/empty come straight from the pointer compare.
module icb_rsp_fifo #(
  parameter  int DEPTH = 4,
  parameter  int WIDTH = 33,
  localparam int PW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] dout_o,
  output logic [PW:0]      count_o,
  output logic             full_o,
  output logic             empty_o
);

  logic [PW:0]      wptr_q, wptr_d;
  logic [PW:0]      rptr_q, rptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             wr_en, rd_en;

  assign wr_en = push_i & ~full_o;
  assign rd_en = pop_i & ~empty_o;

  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[PW] != rptr_q[PW]) &&
                   (wptr_q[PW-1:0] == rptr_q[PW-1:0]);
  assign count_o = wptr_q - rptr_q;
  assign dout_o  = mem_q[rptr_q[PW-1:0]];

  always_comb begin
    wptr_d = wptr_q + {{PW{1'b0}}, wr_en};
    rptr_d = rptr_q + {{PW{1'b0}}, rd_en};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  // Storage is not reset; only entries between the pointers are visible.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wptr_q[PW-1:0]] <= din_i;
    end
  end

endmodule

// File: rtl/icb_slave_sram.sv
// ICB responder on a single-port synchronous SRAM with
// credit-controlled in-order responses and address-error flagging.
module icb_slave_sram
  import icb_pkg::*;
#(
  parameter  logic [ICB_AW-1:0] ADDR_BASE = 32'h1004_0000,
  parameter  int                MEM_DEPTH = 1024,
  parameter  int                RSP_DEPTH = 4,
  localparam int                MAW       = $clog2(MEM_DEPTH),
  localparam int                CW        = $clog2(RSP_DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              icb_cmd_valid,
  output logic              icb_cmd_ready,
  input  logic [ICB_AW-1:0] icb_cmd_addr,
  input  logic              icb_cmd_read,
  input  logic [ICB_DW-1:0] icb_cmd_wdata,
  input  logic [ICB_MW-1:0] icb_cmd_wmask,
  output logic              icb_rsp_valid,
  input  logic              icb_rsp_ready,
  output logic              icb_rsp_err,
  output logic [ICB_DW-1:0] icb_rsp_rdata,
  output logic              sram_cs,
  output logic              sram_we,
  output logic [ICB_MW-1:0] sram_wem,
  output logic [MAW-1:0]    sram_addr,
  output logic [ICB_DW-1:0] sram_din,
  input  logic [ICB_DW-1:0] sram_dout
);

  localparam logic [ICB_AW-1:0] WIN =
    ICB_AW'(4 * MEM_DEPTH);

  logic [ICB_AW-1:0] off;
  logic              hit;
  logic              accept;
  logic              pop;

  logic infl_vld_q, infl_vld_d;
  logic infl_rd_q,  infl_rd_d;
  logic infl_err_q, infl_err_d;

  icb_rsp_t          push_ent;
  icb_rsp_t          head;
  logic [CW-1:0]     fifo_cnt;
  logic              fifo_full;
  logic              fifo_empty;
  logic              fifo_push;
  logic [CW:0]       outst;
  logic [CW:0]       outst_after;

  assign off = icb_cmd_addr - ADDR_BASE;
  assign hit = (off < WIN) && (icb_cmd_addr[1:0] == 2'b00);

  // A slot is granted if one is still free after this cycle's pop.
  assign outst       = {1'b0, fifo_cnt} + {{CW{1'b0}}, infl_vld_q};
  assign outst_after = outst - {{CW{1'b0}}, pop};
  assign icb_cmd_ready = rst_n &
    (outst_after < (CW+1)'(RSP_DEPTH));

  assign accept = icb_cmd_valid & icb_cmd_ready;

  assign sram_cs   = accept & hit;
  assign sram_we   = sram_cs & ~icb_cmd_read;
  assign sram_wem  = sram_we ? icb_cmd_wmask : '0;
  assign sram_addr = off[MAW+1:2];
  assign sram_din  = icb_cmd_wdata;

  always_comb begin
    infl_vld_d = accept;
    infl_rd_d  = accept & icb_cmd_read;
    infl_err_d = accept & ~hit;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      infl_vld_q <= 1'b0;
      infl_rd_q  <= 1'b0;
      infl_err_q <= 1'b0;
    end else begin
      infl_vld_q <= infl_vld_d;
      infl_rd_q  <= infl_rd_d;
      infl_err_q <= infl_err_d;
    end
  end

  assign push_ent = rsp_pack(
    infl_err_q,
    (infl_rd_q & ~infl_err_q) ? sram_dout : '0
  );

  assign fifo_push = infl_vld_q & ~fifo_full;
  assign pop       = icb_rsp_valid & icb_rsp_ready;

  icb_rsp_fifo #(
    .DEPTH (RSP_DEPTH),
    .WIDTH (RSP_W)
  ) u_rsp_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (fifo_push),
    .din_i   (push_ent),
    .pop_i   (pop),
    .dout_o  (head),
    .count_o (fifo_cnt),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign icb_rsp_valid = ~fifo_empty;
  assign icb_rsp_err   = fifo_empty ? 1'b0 : head.err;
  assign icb_rsp_rdata = fifo_empty ? '0 : head.rdata;

endmodule

// File: tb/tb_icb_slave_sram.sv
// Directed + random bench for icb_slave_sram with a behavioural
// SRAM, a word-array reference memory and an expected-response queue.
module tb_icb_slave_sram;

  localparam logic [31:0] BASE  = 32'h1004_0000;
  localparam int          DEPTH = 1024;
  localparam int          RD    = 4;
  localparam logic [31:0] WEND  = BASE + 32'(4 * DEPTH);

  logic        clk = 1'b0;
  logic        rst_n;
  logic        icb_cmd_valid;
  logic        icb_cmd_ready;
  logic [31:0] icb_cmd_addr;
  logic        icb_cmd_read;
  logic [31:0] icb_cmd_wdata;
  logic [3:0]  icb_cmd_wmask;
  logic        icb_rsp_valid;
  logic        icb_rsp_ready;
  logic        icb_rsp_err;
  logic [31:0] icb_rsp_rdata;
  logic        sram_cs;
  logic        sram_we;
  logic [3:0]  sram_wem;
  logic [9:0]  sram_addr;
  logic [31:0] sram_din;
  logic [31:0] sram_dout;

  always #5 clk = ~clk;

  icb_slave_sram #(
    .ADDR_BASE (BASE),
    .MEM_DEPTH (DEPTH),
    .RSP_DEPTH (RD)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .icb_cmd_valid (icb_cmd_valid),
    .icb_cmd_ready (icb_cmd_ready),
    .icb_cmd_addr  (icb_cmd_addr),
    .icb_cmd_read  (icb_cmd_read),
    .icb_cmd_wdata (icb_cmd_wdata),
    .icb_cmd_wmask (icb_cmd_wmask),
    .icb_rsp_valid (icb_rsp_valid),
    .icb_rsp_ready (icb_rsp_ready),
    .icb_rsp_err   (icb_rsp_err),
    .icb_rsp_rdata (icb_rsp_rdata),
    .sram_cs       (sram_cs),
    .sram_we       (sram_we),
    .sram_wem      (sram_wem),
    .sram_addr     (sram_addr),
    .sram_din      (sram_din),
    .sram_dout     (sram_dout)
  );

  // Behavioural single-port SRAM
  logic [31:0] sram [DEPTH];
  always @(posedge clk) begin
    if (sram_cs) begin
      if (sram_we) begin
        for (int b = 0; b < 4; b++)
          if (sram_wem[b])
            sram[sram_addr][8*b +: 8] <= sram_din[8*b +: 8];
      end else begin
        sram_dout <= sram[sram_addr];
      end
    end
  end

  typedef struct {
    bit          err;
    logic [31:0] rdata;
  } exp_t;

  logic [31:0] ref_mem [DEPTH];
  exp_t        exp_q [$];
  int          checks   = 0;
  int          failures = 0;
  int          cyc      = 0;
  int          pops     = 0;
  int          first_pop, last_pop;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit in_window(input logic [31:0] a);
    return (a >= BASE) && (a < WEND) && (a % 4 == 0);
  endfunction

  // Reference: decode each accepted command, predict its response
  bit          m_hit;
  int          m_w;
  exp_t        m_e;
  logic [31:0] m_v;
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
    end else begin
      if (icb_cmd_valid && icb_cmd_ready) begin
        m_hit = in_window(icb_cmd_addr);
        m_w   = int'((icb_cmd_addr - BASE) / 4);
        chk("acc_cs", sram_cs, m_hit);
        m_e.err   = !m_hit;
        m_e.rdata = 32'h0;
        if (m_hit && icb_cmd_read) begin
          m_e.rdata = ref_mem[m_w];
        end else if (m_hit) begin
          m_v = ref_mem[m_w];
          for (int b = 0; b < 4; b++)
            if (icb_cmd_wmask[b])
              m_v[8*b +: 8] = icb_cmd_wdata[8*b +: 8];
          ref_mem[m_w] = m_v;
        end
        exp_q.push_back(m_e);
      end
      if (icb_rsp_valid && icb_rsp_ready) begin
        if (exp_q.size() == 0) begin
          chk("rsp_unexpected", 1, 0);
        end else begin
          m_e = exp_q.pop_front();
          chk("rsp_err", icb_rsp_err, m_e.err);
          chk("rsp_rdata", icb_rsp_rdata, m_e.rdata);
        end
        if (pops == 0) first_pop = cyc;
        last_pop = cyc;
        pops++;
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
  endtask

  // Hold valid until n commands are accepted or maxc cycles elapse
  task automatic burst(input int n, input bit rd,
                       input logic [31:0] a0,
                       input logic [31:0] d0,
                       input logic [31:0] dinc,
                       input logic [3:0] mask,
                       input int maxc,
                       output int acc, output int cy);
    acc = 0;
    cy  = 0;
    @(posedge clk); #1;
    icb_cmd_valid = 1'b1;
    icb_cmd_read  = rd;
    icb_cmd_addr  = a0;
    icb_cmd_wdata = d0;
    icb_cmd_wmask = mask;
    while (acc < n && cy < maxc) begin
      @(negedge clk);
      cy++;
      if (icb_cmd_ready) acc++;
      @(posedge clk); #1;
      icb_cmd_addr  = a0 + 32'(4 * acc);
      icb_cmd_wdata = d0 + dinc * 32'(acc);
      if (acc >= n) icb_cmd_valid = 1'b0;
    end
    icb_cmd_valid = 1'b0;
  endtask

  initial begin
    int acc, cy, sent, r;
    bit took;
    for (int i = 0; i < DEPTH; i++) begin
      sram[i]    = 32'h0;
      ref_mem[i] = 32'h0;
    end
    sram_dout     = 32'h0;
    rst_n         = 1'b0;
    icb_cmd_valid = 1'b1;
    icb_cmd_read  = 1'b1;
    icb_cmd_addr  = BASE;
    icb_cmd_wdata = 32'h0;
    icb_cmd_wmask = 4'h0;
    icb_rsp_ready = 1'b0;

    #2;
    chk("rst_cmd_ready", icb_cmd_ready, 0);
    chk("rst_rsp_valid", icb_rsp_valid, 0);
    chk("rst_sram_cs", sram_cs, 0);
    chk("rst_rsp_err", icb_rsp_err, 0);
    chk("rst_rsp_rdata", icb_rsp_rdata, 0);
    icb_cmd_valid = 1'b0;
    @(posedge clk); #3;
    rst_n = 1'b1;
    icb_rsp_ready = 1'b1;

    // write then read with latency check
    burst(1, 0, BASE + 32'h10, 32'hDEADBEEF, 0, 4'hF, 10, acc, cy);
    burst(1, 1, BASE + 32'h10, 0, 0, 4'h0, 10, acc, cy);
    @(negedge clk);
    chk("lat_n1_valid", icb_rsp_valid, 0);
    @(negedge clk);
    chk("lat_n2_valid", icb_rsp_valid, 1);
    chk("wr_rd_data", icb_rsp_rdata, 32'hDEADBEEF);
    chk("wr_rd_err", icb_rsp_err, 0);

    // byte mask, then a zero-mask write must leave the word alone
    burst(1, 0, BASE + 32'h20, 32'hFFFFFFFF, 0, 4'hF, 10, acc, cy);
    burst(1, 0, BASE + 32'h20, 32'h11223344, 0, 4'b0101, 10, acc, cy);
    burst(1, 1, BASE + 32'h20, 0, 0, 4'h0, 10, acc, cy);
    @(negedge clk); @(negedge clk);
    chk("mask_data", icb_rsp_rdata, 32'hFF22FF44);
    burst(1, 0, BASE + 32'h20, 32'h0, 0, 4'h0, 10, acc, cy);
    burst(1, 1, BASE + 32'h20, 0, 0, 4'h0, 10, acc, cy);
    @(negedge clk); @(negedge clk);
    chk("mask0_data", icb_rsp_rdata, 32'hFF22FF44);

    // address errors: just past the window and misaligned
    burst(1, 1, WEND, 0, 0, 4'h0, 10, acc, cy);
    @(negedge clk); @(negedge clk);
    chk("err_end_err", icb_rsp_err, 1);
    chk("err_end_rdata", icb_rsp_rdata, 0);
    burst(1, 1, BASE + 32'h2, 0, 0, 4'h0, 10, acc, cy);
    @(negedge clk); @(negedge clk);
    chk("err_mis_err", icb_rsp_err, 1);
    chk("err_mis_rdata", icb_rsp_rdata, 0);
    idle(3);

    // backpressure
    @(posedge clk); #1;
    icb_rsp_ready = 1'b0;
    burst(6, 1, BASE, 0, 0, 4'h0, 10, acc, cy);
    chk("bp_accepted", acc, RD);
    @(negedge clk);
    chk("bp_cmd_ready", icb_cmd_ready, 0);
    @(posedge clk); #1;
    pops = 0;
    icb_rsp_ready = 1'b1;
    burst(2, 1, BASE + 32'(4 * RD), 0, 0, 4'h0, 20, acc, cy);
    chk("bp_rest", acc, 2);
    idle(6);
    chk("bp_pops", pops, 6);
    chk("bp_queue", exp_q.size(), 0);

    // throughput: preload index, then 16 back-to-back reads
    burst(16, 0, BASE, 0, 1, 4'hF, 40, acc, cy);
    chk("tp_wr_acc", acc, 16);
    idle(4);
    pops = 0;
    burst(16, 1, BASE, 0, 0, 4'h0, 40, acc, cy);
    chk("tp_rd_acc", acc, 16);
    chk("tp_rd_cycles", cy, 16);
    idle(5);
    chk("tp_pops", pops, 16);
    chk("tp_span", last_pop - first_pop, 15);

    // random traffic with random response backpressure
    sent = 0;
    took = 1'b0;
    for (int c = 0; c < 3000 && sent < 80; c++) begin
      @(posedge clk); #1;
      icb_rsp_ready = ($urandom_range(0, 3) != 0);
      if (!icb_cmd_valid || took) begin
        icb_cmd_valid = ($urandom_range(0, 4) != 0);
        icb_cmd_read  = 1'($urandom_range(0, 1));
        icb_cmd_wdata = $urandom;
        icb_cmd_wmask = 4'($urandom_range(0, 15));
        r = $urandom_range(0, 9);
        case (r)
          0: icb_cmd_addr = WEND + 32'(4 * $urandom_range(0, 15));
          1: icb_cmd_addr = BASE + 32'(4 * $urandom_range(0, 63))
                                 + 32'($urandom_range(1, 3));
          2: icb_cmd_addr = BASE - 32'h4;
          3: icb_cmd_addr = WEND - 32'(4 * $urandom_range(1, 4));
          default: icb_cmd_addr = BASE + 32'(4 * $urandom_range(0, 63));
        endcase
      end
      @(negedge clk);
      took = icb_cmd_valid && icb_cmd_ready;
      if (took) sent++;
    end
    @(posedge clk); #1;
    icb_cmd_valid = 1'b0;
    icb_rsp_ready = 1'b1;
    chk("rnd_sent", sent, 80);
    idle(8);
    chk("rnd_queue", exp_q.size(), 0);

    // reset with responses queued
    @(posedge clk); #1;
    icb_rsp_ready = 1'b0;
    burst(3, 1, BASE, 0, 0, 4'h0, 10, acc, cy);
    chk("rst_q_acc", acc, 3);
    idle(2);
    @(negedge clk);
    chk("rst_q_valid", icb_rsp_valid, 1);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk("arst_rsp_valid", icb_rsp_valid, 0);
    chk("arst_cmd_ready", icb_cmd_ready, 0);
    chk("arst_rsp_rdata", icb_rsp_rdata, 0);
    idle(2); #3;
    rst_n = 1'b1;
    icb_rsp_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("post_rst_valid", icb_rsp_valid, 0);
    end
    burst(1, 1, BASE + 32'h8, 0, 0, 4'h0, 10, acc, cy);
    @(negedge clk); @(negedge clk);
    chk("post_rst_data", icb_rsp_rdata, 32'h2);
    idle(3);
    chk("post_rst_queue", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
